vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 19, VRAM address width (640x480 = 307200 words).
REQ-002 Parameter: DATA_W, 12, pixel width (4-bit R, G, B).
REQ-003 Parameter: FIFO_DEPTH, 4, write-buffer entries; power of two, at least 2.
REQ-004 vga_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstn  in  1  reset; asynchronous, active-low.
REQ-006 vga_rdn  in  1  scanout read request, active-low; 0 = read vga_addr this cycle.
REQ-007 vga_addr  in  ADDR_W  scanout pixel address.
REQ-008 vga_color  out  DATA_W  registered pixel data returned to scanout.
REQ-009 wr_valid  in  1  writer offers one pixel write.
REQ-010 wr_addr  in  ADDR_W  writer pixel address.
REQ-011 wr_data  in  DATA_W  writer pixel colour.
REQ-012 wr_ready  out  1  write FIFO can accept; transfer when wr_valid and wr_ready are both 1.
REQ-013 mem_addr  out  ADDR_W  VRAM address; combinational.
REQ-014 mem_we  out  1  VRAM write enable, active-high; combinational.
REQ-015 mem_wdata  out  DATA_W  VRAM write data; combinational.
REQ-016 mem_rdata  in  DATA_W  VRAM read data, valid one cycle after the read address.
REQ-017 fifo_count  out  $clog2(FIFO_DEPTH)+1  current write-FIFO occupancy.
REQ-018 state  out  2  FSM state: IDLE = 0, DRAIN = 1, HOLD = 2.

Function
REQ-019 Arbitration: scanout has absolute priority. A cycle with vga_rdn = 0 is a read grant: mem_addr = vga_addr, mem_we = 0.
REQ-020 When vga_rdn = 1 and the FIFO is non-empty: drive the FIFO head (mem_addr = head addr, mem_wdata = head data, mem_we = 1) and pop the head at the clock edge.
REQ-021 When vga_rdn = 1 and the FIFO is empty: mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-022 The block never stalls or delays scanout; no writer input affects read timing.
REQ-023 Read return, registered rd_pend flag:
  - rd_pend = ~vga_rdn, captured each edge.
  - At each edge, vga_color <= rd_pend ? mem_rdata : 0.
  - vga_color reflects the cycle-N read from the edge ending cycle N+1 (two-edge latency).
  - vga_color is 0 during blanking.
REQ-024 Write FIFO: circular buffer of {addr, data}, FIFO_DEPTH entries, strict in-order drain.
REQ-025 wr_ready = (fifo_count < FIFO_DEPTH); it depends only on registered count, not on a same-cycle pop.
REQ-026 Simultaneous push and pop: both happen; fifo_count is unchanged; the pushed entry goes behind the popped one.
REQ-027 Full FIFO: wr_ready = 0; wr_valid is ignored and the FIFO is not corrupted.
REQ-028 Empty FIFO with a push in a vga_rdn = 1 cycle: the new entry is not written that cycle; it is written at the earliest in the next cycle.
REQ-029 Pointers wrap modulo FIFO_DEPTH; fifo_count never exceeds FIFO_DEPTH and never underflows.
REQ-030 FSM, registered, next-state from post-edge count and vga_rdn:
  - IDLE: FIFO empty.
  - DRAIN: FIFO non-empty and vga_rdn = 1.
  - HOLD: FIFO non-empty and vga_rdn = 0.
  - Any state may move to any state in one cycle.
  - The state output is informational; arbitration follows REQ-019 to REQ-021 combinationally.
REQ-031 Address and data are passed through unmodified; no range check (the writer guarantees addr < 307200).

Reset
REQ-032 rstn = 0 immediately clears:
  - FIFO pointers; fifo_count = 0.
  - rd_pend = 0; vga_color = 0.
  - state = IDLE.
  - Result: wr_ready = 1, and mem_we = 0 whenever vga_rdn = 1.
REQ-033 Reset mid-operation discards all buffered writes; no partial write is issued after rstn asserts.
REQ-034 After rstn deasserts, normal operation resumes at the first rising edge.

Verification
REQ-035 Read latency:
  - Stimulus: vga_rdn = 0 for 3 cycles at addrs 0, 1, 2; mem model returns data = addr+0x100.
  - Required: mem_addr follows 0, 1, 2 in the same cycle; mem_we = 0 throughout; vga_color = 0x100, 0x101, 0x102 on consecutive edges starting two edges after the first read; then 0.
REQ-036 Blanking drain:
  - Stimulus: with vga_rdn = 1, push (0x10, 0xABC) and (0x11, 0x123).
  - Required: mem_we = 1 with addr 0x10, then 0x11 on the following cycles, in order; fifo_count returns to 0; state DRAIN -> IDLE.
REQ-037 Full during active display:
  - Stimulus: vga_rdn = 0; push 5 writes.
  - Required: first 4 accepted; wr_ready = 0 at fifo_count = 4; 5th held; mem_we stays 0; state = HOLD.
  - Continue: release vga_rdn = 1. Required: 4 writes drain in order, then the 5th is accepted.
REQ-038 Simultaneous events:
  - Stimulus: fifo_count = 2, vga_rdn = 1, push in the same cycle.
  - Required: head written; fifo_count stays 2; the new entry is written after the older remaining entry.
REQ-039 Reset mid-drain:
  - Stimulus: assert rstn = 0 asynchronously with 3 entries buffered.
  - Required: fifo_count = 0, vga_color = 0, state = IDLE, wr_ready = 1 before the next edge; no further mem_we pulses.
REQ-040 Randomized pointer wrap:
  - Stimulus: 1000 cycles of random wr_valid and vga_rdn.
  - Required: the VRAM model matches a reference write log exactly; no write is lost or duplicated.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, scanout reads win every cycle.
// Writer pixels are queued in a small FIFO and drained when scanout is idle.
//
// Ports:
//   vga_clk, rstn              clock, async active-low reset
//   vga_rdn, vga_addr          scanout read request (active-low) and address
//   vga_color                  registered read data, 0 during blanking
//   wr_valid/wr_ready          writer handshake; wr_addr, wr_data carry the pixel
//   mem_addr/mem_we/mem_wdata  VRAM port (combinational)
//   mem_rdata                  VRAM read data, one cycle after the address
//   fifo_count, state          write-FIFO occupancy and FSM state (IDLE/DRAIN/HOLD)
module vram_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          vga_clk,
   input  logic                          rstn,
   input  logic                          vga_rdn,
   input  logic [ADDR_W-1:0]             vga_addr,
   output logic [DATA_W-1:0]             vga_color,
   input  logic                          wr_valid,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ready,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic                          mem_we,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [1:0]                    state
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t state_q, state_n;

   logic [ADDR_W-1:0] f_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] f_data [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count_n;
   logic              empty, push, pop;
   logic              rd_pend;

   assign empty    = (fifo_count == '0);
   // Ready comes from the registered count only, so a full FIFO
   // refuses a write even in a cycle where it is popping.
   assign wr_ready = (fifo_count < DEPTH_C);
   assign push     = wr_valid & wr_ready;
   // Pop uses the registered count: a write pushed into an empty
   // FIFO is never forwarded to VRAM in the same cycle.
   assign pop      = vga_rdn & ~empty;
   assign state    = state_q;

   always_comb begin
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      unique case (1'b1)
         !vga_rdn: begin
            mem_addr = vga_addr;
         end
         pop: begin
            mem_addr  = f_addr[rd_ptr];
            mem_wdata = f_data[rd_ptr];
            mem_we    = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      count_n = fifo_count;
      unique case ({push, pop})
         2'b10:   count_n = fifo_count + CW'(1);
         2'b01:   count_n = fifo_count - CW'(1);
         default: count_n = fifo_count;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (push) begin
         f_addr[wr_ptr] <= wr_addr;
         f_data[wr_ptr] <= wr_data;
      end
   end

   // Pointers are PW bits wide, so they wrap modulo FIFO_DEPTH.
   always_ff @(posedge vga_clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fifo_count <= count_n;
      end
   end

   // Two-edge read return: the address is registered by the VRAM,
   // then the data is registered here.
   always_ff @(posedge vga_clk or negedge rstn) begin
      if (!rstn) begin
         rd_pend   <= 1'b0;
         vga_color <= '0;
      end else begin
         rd_pend   <= ~vga_rdn;
         vga_color <= rd_pend ? mem_rdata : '0;
      end
   end

   always_ff @(posedge vga_clk or negedge rstn) begin
      if (!rstn) state_q <= IDLE;
      else       state_q <= state_n;
   end

   always_comb begin
      state_n = IDLE;
      if (count_n == '0) state_n = IDLE;
      else if (vga_rdn)  state_n = DRAIN;
      else               state_n = HOLD;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and random checks of vram_arbiter
// against a queue-based model of the write buffer and VRAM.
module tb_vram_arbiter;

   localparam int AW = 19;
   localparam int DW = 12;
   localparam int D  = 4;

   logic          vga_clk, rstn, vga_rdn;
   logic [AW-1:0] vga_addr;
   logic [DW-1:0] vga_color;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] wr_addr, mem_addr;
   logic [DW-1:0] wr_data, mem_wdata, mem_rdata;
   logic          mem_we;
   logic [2:0]    fifo_count;
   logic [1:0]    state;

   vram_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(D)
   ) dut (
      .vga_clk(vga_clk), .rstn(rstn),
      .vga_rdn(vga_rdn), .vga_addr(vga_addr),
      .vga_color(vga_color),
      .wr_valid(wr_valid), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_ready(wr_ready),
      .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .fifo_count(fifo_count), .state(state)
   );

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t           q[$];
   logic [DW-1:0] ref_vram [int];
   logic [DW-1:0] vram [int];
   int            checks, errors;
   int            nwr_dut, nwr_exp;
   bit            accepted;
   bit            pend;
   logic [DW-1:0] pend_d;

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   // VRAM: synchronous read; unwritten words read as addr+0x100.
   always @(posedge vga_clk) begin : vram_m
      logic [DW-1:0] r;
      r = vram.exists(int'(mem_addr)) ?
          vram[int'(mem_addr)] : DW'(mem_addr + 19'h100);
      if (mem_we) begin
         vram[int'(mem_addr)] = mem_wdata;
         nwr_dut++;
      end
      mem_rdata <= r;
   end

   function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
      return ref_vram.exists(int'(a)) ?
             ref_vram[int'(a)] : DW'(a + 19'h100);
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, "_cnt"}, 32'(fifo_count), 0);
      check({tag, "_col"}, 32'(vga_color), 0);
      check({tag, "_st"}, 32'(state), 0);
      check({tag, "_rdy"}, 32'(wr_ready), 1);
      check({tag, "_we"}, 32'(mem_we), 0);
   endtask

   // One cycle: check combinational outputs, advance the model
   // at the rising edge, check registered outputs at the falling edge.
   task automatic step();
      bit            push, pop, rd;
      logic [AW-1:0] ra;
      logic [DW-1:0] ecol;
      int            est;
      #1;
      check("wr_ready", 32'(wr_ready), 32'(q.size() < D));
      if (!vga_rdn) begin
         check("rd_addr", 32'(mem_addr), 32'(vga_addr));
         check("rd_we", 32'(mem_we), 0);
      end else if (q.size() != 0) begin
         check("wr_we", 32'(mem_we), 1);
         check("wr_addr", 32'(mem_addr), 32'(q[0].a));
         check("wr_data", 32'(mem_wdata), 32'(q[0].d));
      end else begin
         check("idle_we", 32'(mem_we), 0);
         check("idle_addr", 32'(mem_addr), 0);
         check("idle_data", 32'(mem_wdata), 0);
      end
      push = wr_valid && (q.size() < D);
      pop  = vga_rdn && (q.size() != 0);
      rd   = !vga_rdn;
      ra   = vga_addr;
      @(posedge vga_clk);
      if (pop) begin
         ref_vram[int'(q[0].a)] = q[0].d;
         nwr_exp++;
         void'(q.pop_front());
      end
      if (push) q.push_back('{wr_addr, wr_data});
      accepted = push;
      ecol   = pend ? pend_d : '0;
      pend   = rd;
      pend_d = rd ? rd_val(ra) : '0;
      est = (q.size() == 0) ? 0 : (rd ? 2 : 1);
      @(negedge vga_clk);
      check("count", 32'(fifo_count), 32'(q.size()));
      check("state", 32'(state), 32'(est));
      check("color", 32'(vga_color), 32'(ecol));
   endtask

   task automatic drive(input bit rdn, input logic [AW-1:0] ra,
                        input bit wv, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd);
      vga_rdn  = rdn;
      vga_addr = ra;
      wr_valid = wv;
      wr_addr  = wa;
      wr_data  = wd;
   endtask

   initial begin
      int idx;
      checks = 0; errors = 0;
      nwr_dut = 0; nwr_exp = 0;
      pend = 0; pend_d = '0;
      drive(1, 0, 0, 0, 0);
      rstn = 1'b1;
      #2 rstn = 1'b0;
      #1 reset_checks("rst0");
      @(negedge vga_clk);
      rstn = 1'b1;

      // read latency
      for (int i = 0; i < 3; i++) begin
         drive(0, AW'(i), 0, 0, 0);
         step();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0);
         step();
      end

      // blanking drain
      drive(1, 0, 1, 19'h10, 12'hABC); step();
      drive(1, 0, 1, 19'h11, 12'h123); step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0);
         step();
      end

      // full FIFO during active display, then release
      idx = 0;
      for (int c = 0; c < 14; c++) begin
         drive(c < 7 ? 1'b0 : 1'b1, AW'(c + 40),
               idx < 5, AW'(19'h20 + idx),
               DW'(12'h500 + idx));
         step();
         if (accepted) idx++;
      end
      check("full_all_accepted", 32'(idx), 5);

      // simultaneous push and pop at count 2
      drive(0, 7, 1, 19'h30, 12'h0A1); step();
      drive(0, 8, 1, 19'h31, 12'h0A2); step();
      drive(1, 0, 1, 19'h32, 12'h0A3); step();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0);
         step();
      end

      // reset with three entries buffered
      for (int i = 0; i < 3; i++) begin
         drive(0, AW'(i), 1, AW'(19'h40 + i), DW'(12'h7A0 + i));
         step();
      end
      drive(1, 0, 0, 0, 0);
      #2 rstn = 1'b0;
      #1 reset_checks("rst_mid");
      q.delete();
      pend = 0;
      pend_d = '0;
      @(negedge vga_clk);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) step();

      // random traffic with pointer wrap
      for (int i = 0; i < 1000; i++) begin
         int pr;
         pr = ((i / 50) % 2 == 0) ? 80 : 15;
         drive($urandom_range(0, 99) < pr ? 1'b0 : 1'b1,
               AW'($urandom_range(0, 63)),
               1'($urandom_range(0, 1)),
               AW'($urandom_range(0, 63)),
               DW'($urandom));
         step();
      end
      drive(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step();

      check("write_total", 32'(nwr_dut), 32'(nwr_exp));
      foreach (ref_vram[k]) begin
         check("vram_exists", 32'(vram.exists(k)), 1);
         check("vram_word",
               vram.exists(k) ? 32'(vram[k]) : 32'hFFFF_FFFF,
               32'(ref_vram[k]));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
